kd_tree_sequencer: RTL and testbench
====================================

Name: kd_tree_sequencer

Overview:
- Central controller for the kd-tree cluster PE array. It broadcasts the per-cycle control strobes that every cluster PE consumes.
- Sequences one full k-means run: init, then per iteration start, per-point receive/sort/increment, then update and a stability check.
- Streams data points in over a valid/ready interface and rebroadcasts them on a shared point bus. Stops on global stability or after max_iter iterations.

Parameters:
dim, 3, number of dimensions per point
data_range, 255, max value per dimension; dim_size = $clog2(data_range)
max_n, 1000, max points per run; counter_size = $clog2(max_n)
max_depth, 16, max tree depth; depth_size = $clog2(max_depth)
max_iter, 64, iteration cap; iter_size = $clog2(max_iter+1)
center_size = dim*dim_size (localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin run; sampled only in IDLE
abort  in  1  synchronous abort to IDLE
num_points  in  counter_size  N, latched on accepted start
tree_depth  in  depth_size  D (levels swept per point), latched on accepted start
pt_valid  in  1  point stream valid
pt_data  in  center_size  point stream data
pt_ready  out  1  point stream ready
point_out  out  center_size  registered point broadcast to PEs
pe_en, pe_init, pe_start_iter, pe_receive_point, pe_sorting, pe_next_level, pe_inc, pe_update  out  1 each  PE control strobes
update_done  in  1  AND of PE update-complete flags
all_stable  in  1  AND of PE stable outputs
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
converged  out  1  last run ended on stability
iter_count  out  iter_size  iterations completed in last/current run

Behaviour:
- Reset (async): state=IDLE. All outputs are 0, including point_out, iter_count and converged. Internal counters are cleared. Reset mid-run abandons the run with no done pulse.
- pe_en = busy. busy=1 in every state except IDLE. All strobes are Moore outputs decoded from the state register.
- IDLE:
  - On start=1 with num_points!=0: latch N and D (D=0 is treated as 1), clear iter_count and converged, go to INIT.
  - On start=1 with num_points==0: go to DONE with converged=0 and iter_count=0.
  - start while busy is ignored.
- INIT: pe_init=1 for 1 cycle, then START_ITER.
- START_ITER: pe_start_iter=1 for 1 cycle; pt_idx<=0; then FETCH.
- FETCH:
  - pt_ready=1 only in this state.
  - On pt_valid&&pt_ready: point_out<=pt_data, go to LOAD. Otherwise stay.
  - point_out holds its value outside FETCH handshakes.
- LOAD: pe_receive_point=1 for 1 cycle (point_out is stable this cycle); lvl<=0; then SORT_A.
- SORT_A: pe_sorting=1 for 1 cycle, then SORT_B.
- SORT_B:
  - pe_next_level=1 for 1 cycle.
  - If lvl==D-1, go to INC; else lvl++ and go to SORT_A.
  - Exactly D pe_sorting and D pe_next_level pulses per point, alternating.
- INC:
  - pe_inc=1 for 1 cycle.
  - If pt_idx==N-1, go to UPDATE; else pt_idx++ and go to FETCH.
- UPDATE:
  - pe_update held 1 until update_done is sampled 1; then CHECK.
  - update_done outside UPDATE is ignored.
- CHECK: iter_count++.
  - If all_stable: converged<=1, go to DONE.
  - Else if iter_count+1==max_iter: converged<=0, go to DONE.
  - Else go to START_ITER.
- DONE: done=1 for 1 cycle, then IDLE. converged and iter_count hold until the next accepted start.
- abort=1 in any non-IDLE state: next state is IDLE, no done pulse, iter_count holds. abort has priority over every transition. abort in IDLE has no effect.
- Per-point latency with pt_valid held high: 1 FETCH + 1 LOAD + 2D SORT + 1 INC = 2D+3 cycles.
- Per-iteration latency: 1 + N(2D+3) + U + 1, where U = cycles in UPDATE (≥1).
- Counters never wrap: pt_idx < N ≤ max_n, lvl < D, iter_count ≤ max_iter.

Test Plan:
- Nominal run: N=4, D=3, pt_valid always high, update_done=1 on the first UPDATE cycle, all_stable=1.
  - Required: 1 pe_init, 1 pe_start_iter, 4 pe_receive_point, 12 pe_sorting, 12 pe_next_level, 4 pe_inc.
  - Each point takes 9 cycles; 4 points ride point_out in order.
  - done pulses; converged=1, iter_count=1.
- Backpressure: N=3, D=2, pt_valid low 5 cycles before each point.
  - Required: pt_ready stays 1 through the gaps; no strobes toggle while waiting; point_out captures only accepted data; pulse counts are 3/6/6/3.
- Iteration cap: max_iter=3, all_stable=0, N=2, D=1.
  - Required: 3 pe_start_iter pulses, then done; converged=0, iter_count=3.
- Zero points: start with num_points=0.
  - Required: no PE strobes; done pulses 2 cycles after start; iter_count=0, converged=0.
- Async reset mid-SORT_B: assert rst between clock edges.
  - Required: all outputs go to 0 immediately without waiting for a clock edge.
  - After release, start with N=1, D=1 runs cleanly: 1/1/1/1 pulse counts.
- Abort and stall: abort during UPDATE with update_done held 0 for 10 cycles.
  - Required: IDLE next cycle, pe_update drops, no done pulse.
  - A start issued during the run before the abort is ignored.

Source files
------------

// File: rtl/kd_tree_sequencer_if.sv
// kd_tree_sequencer_if
// Groups the sequencer's bus-facing signals: the incoming point stream
// (valid/ready/data), the registered point broadcast, the PE control
// strobes, and the two AND-reduced status flags returned by the PE array.
//   master : sequencer side (drives point_out, strobes and pt_ready)
//   slave  : point source / PE array side
interface kd_tree_sequencer_if #(
  parameter int CENTER_W = 24
);
  logic                pt_valid;
  logic                pt_ready;
  logic [CENTER_W-1:0] pt_data;
  logic [CENTER_W-1:0] point_out;
  logic                pe_en;
  logic                pe_init;
  logic                pe_start_iter;
  logic                pe_receive_point;
  logic                pe_sorting;
  logic                pe_next_level;
  logic                pe_inc;
  logic                pe_update;
  logic                update_done;
  logic                all_stable;

  modport master (
    input  pt_valid, pt_data, update_done, all_stable,
    output pt_ready, point_out, pe_en, pe_init, pe_start_iter,
           pe_receive_point, pe_sorting, pe_next_level, pe_inc, pe_update
  );

  modport slave (
    output pt_valid, pt_data, update_done, all_stable,
    input  pt_ready, point_out, pe_en, pe_init, pe_start_iter,
           pe_receive_point, pe_sorting, pe_next_level, pe_inc, pe_update
  );
endinterface

// File: rtl/kd_tree_sequencer.sv
// kd_tree_sequencer
// Central controller for the kd-tree cluster PE array. Sequences one k-means
// run (init, then per iteration: start, per point fetch/receive/sort/inc,
// update, stability check) and broadcasts Moore-decoded control strobes.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, abort        : run request (IDLE only) / abort back to IDLE
//   num_points          : N, latched on accepted start
//   tree_depth          : D, levels swept per point (0 treated as 1)
//   bus (master)        : point stream in, point broadcast + PE strobes out,
//                         update_done / all_stable in
//   busy, done          : run in progress / one-cycle completion pulse
//   converged           : last run ended on stability
//   iter_count          : iterations completed in last/current run
module kd_tree_sequencer #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int max_n      = 1000,
  parameter int max_depth  = 16,
  parameter int max_iter   = 64,
  localparam int dim_size     = $clog2(data_range),
  localparam int counter_size = $clog2(max_n),
  localparam int depth_size   = $clog2(max_depth),
  localparam int iter_size    = $clog2(max_iter + 1),
  localparam int center_size  = dim * dim_size
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [counter_size-1:0] num_points,
  input  logic [depth_size-1:0]   tree_depth,
  kd_tree_sequencer_if.master     bus,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [iter_size-1:0]    iter_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_START_ITER, S_FETCH, S_LOAD, S_SORT_A, S_SORT_B,
    S_INC, S_UPDATE, S_CHECK, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [counter_size-1:0] n_q, n_d;
  logic [counter_size-1:0] pt_idx_q, pt_idx_d;
  logic [depth_size-1:0]   d_q, d_d;
  logic [depth_size-1:0]   lvl_q, lvl_d;
  logic [iter_size-1:0]    iter_q, iter_d;
  logic                    conv_q, conv_d;
  logic [center_size-1:0]  point_q, point_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      pt_idx_q <= '0;
      d_q      <= '0;
      lvl_q    <= '0;
      iter_q   <= '0;
      conv_q   <= 1'b0;
      point_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      pt_idx_q <= pt_idx_d;
      d_q      <= d_d;
      lvl_q    <= lvl_d;
      iter_q   <= iter_d;
      conv_q   <= conv_d;
      point_q  <= point_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    pt_idx_d = pt_idx_q;
    d_d      = d_q;
    lvl_d    = lvl_q;
    iter_d   = iter_q;
    conv_d   = conv_q;
    point_d  = point_q;
    // Abort wins over every transition and freezes all run state.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            iter_d = '0;
            conv_d = 1'b0;
            if (num_points != '0) begin
              n_d     = num_points;
              d_d     = (tree_depth == '0) ? depth_size'(1) : tree_depth;
              state_d = S_INIT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_INIT:       state_d = S_START_ITER;
        S_START_ITER: begin
          pt_idx_d = '0;
          state_d  = S_FETCH;
        end
        S_FETCH: begin
          if (bus.pt_valid) begin
            point_d = bus.pt_data;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          lvl_d   = '0;
          state_d = S_SORT_A;
        end
        S_SORT_A:     state_d = S_SORT_B;
        S_SORT_B: begin
          if (lvl_q == d_q - depth_size'(1)) begin
            state_d = S_INC;
          end else begin
            lvl_d   = lvl_q + depth_size'(1);
            state_d = S_SORT_A;
          end
        end
        S_INC: begin
          if (pt_idx_q == n_q - counter_size'(1)) begin
            state_d = S_UPDATE;
          end else begin
            pt_idx_d = pt_idx_q + counter_size'(1);
            state_d  = S_FETCH;
          end
        end
        S_UPDATE: begin
          if (bus.update_done) state_d = S_CHECK;
        end
        S_CHECK: begin
          iter_d = iter_q + iter_size'(1);
          if (bus.all_stable) begin
            conv_d  = 1'b1;
            state_d = S_DONE;
          end else if (iter_q == iter_size'(max_iter - 1)) begin
            conv_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_START_ITER;
          end
        end
        S_DONE:       state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign busy                 = (state_q != S_IDLE);
  assign done                 = (state_q == S_DONE);
  assign converged            = conv_q;
  assign iter_count           = iter_q;
  assign bus.pt_ready         = (state_q == S_FETCH);
  assign bus.point_out        = point_q;
  assign bus.pe_en            = busy;
  assign bus.pe_init          = (state_q == S_INIT);
  assign bus.pe_start_iter    = (state_q == S_START_ITER);
  assign bus.pe_receive_point = (state_q == S_LOAD);
  assign bus.pe_sorting       = (state_q == S_SORT_A);
  assign bus.pe_next_level    = (state_q == S_SORT_B);
  assign bus.pe_inc           = (state_q == S_INC);
  assign bus.pe_update        = (state_q == S_UPDATE);

endmodule

// File: tb/tb_kd_tree_sequencer.sv
// Testbench for kd_tree_sequencer: an expected per-cycle output trace is
// built from the run rules (points, levels, update length, stability) and
// compared cycle by cycle; strobe counts and final status are pinned with
// hand-computed literals.
module tb_kd_tree_sequencer;
  localparam int MAXIT = 3;
  localparam int CW    = 24;
  localparam int NW    = 10;
  localparam int DW    = 4;
  localparam int IW    = $clog2(MAXIT + 1);

  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_INIT  = 7'b1000000;
  localparam logic [6:0] S_START = 7'b0100000;
  localparam logic [6:0] S_RECV  = 7'b0010000;
  localparam logic [6:0] S_SORT  = 7'b0001000;
  localparam logic [6:0] S_NEXT  = 7'b0000100;
  localparam logic [6:0] S_INC   = 7'b0000010;
  localparam logic [6:0] S_UPD   = 7'b0000001;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rdy;
    logic [6:0]    stb;
    logic          conv;
    logic [IW-1:0] iter;
    logic [CW-1:0] pt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [NW-1:0] num_points;
  logic [DW-1:0] tree_depth;
  logic busy, done, converged;
  logic [IW-1:0] iter_count;

  always #5 clk = ~clk;

  kd_tree_sequencer_if #(.CENTER_W(CW)) bus();

  kd_tree_sequencer #(.max_iter(MAXIT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_points(num_points), .tree_depth(tree_depth), .bus(bus),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count)
  );

  logic [CW-1:0] pts [8] = '{24'h0A1B2C, 24'h112233, 24'hFF00FF, 24'h010203,
                             24'h7F8081, 24'hABCDEF, 24'h00FF00, 24'h102030};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  bit chk_en = 0;

  // Model state carried between runs
  logic [CW-1:0] cur_pt = '0;
  int m_iter = 0;
  int m_conv = 0;

  // Stimulus state
  int pi, gap_cnt, ucnt;

  int c_init, c_start, c_recv, c_sort, c_next, c_inc, c_upd, c_done;

  function automatic exp_t actual();
    exp_t a;
    a.busy = busy;
    a.done = done;
    a.rdy  = bus.pt_ready;
    a.stb  = {bus.pe_init, bus.pe_start_iter, bus.pe_receive_point,
              bus.pe_sorting, bus.pe_next_level, bus.pe_inc, bus.pe_update};
    a.conv = converged;
    a.iter = iter_count;
    a.pt   = bus.point_out;
    return a;
  endfunction

  // Single compare process against the expected trace
  always @(negedge clk) begin
    if (chk_en && exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = actual();
      cyc++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d actual=%h required=%h", cyc, a, e);
      end
      checks++;
      if (bus.pe_en !== e.busy) begin
        errors++;
        $display("FAIL pe_en cyc=%0d actual=%b required=%b", cyc, bus.pe_en, e.busy);
      end
      c_init  += int'(bus.pe_init);
      c_start += int'(bus.pe_start_iter);
      c_recv  += int'(bus.pe_receive_point);
      c_sort  += int'(bus.pe_sorting);
      c_next  += int'(bus.pe_next_level);
      c_inc   += int'(bus.pe_inc);
      c_upd   += int'(bus.pe_update);
      c_done  += int'(done);
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic r, input logic [6:0] s);
    exp_t e;
    e.busy = b;
    e.done = d;
    e.rdy  = r;
    e.stb  = s;
    e.conv = (m_conv != 0);
    e.iter = IW'(m_iter);
    e.pt   = cur_pt;
    exp_q.push_back(e);
  endtask

  // Expected trace from the cycle after start is accepted to the first IDLE cycle
  task automatic plan(input int n, input int d, input int gap, input int u,
                      input int stable, input int abort_upd);
    int deff;
    int pidx;
    pidx = 0;
    deff = (d == 0) ? 1 : d;
    m_iter = 0;
    m_conv = 0;
    if (n == 0) begin
      push(1, 1, 0, S_NONE);
      push(0, 0, 0, S_NONE);
      return;
    end
    push(1, 0, 0, S_INIT);
    for (int k = 0; k < MAXIT; k++) begin
      push(1, 0, 0, S_START);
      for (int j = 0; j < n; j++) begin
        for (int g = 0; g <= gap; g++) push(1, 0, 1, S_NONE);
        cur_pt = pts[pidx % 8];
        pidx++;
        push(1, 0, 0, S_RECV);
        for (int l = 0; l < deff; l++) begin
          push(1, 0, 0, S_SORT);
          push(1, 0, 0, S_NEXT);
        end
        push(1, 0, 0, S_INC);
      end
      if (abort_upd > 0) begin
        for (int t = 0; t < abort_upd; t++) push(1, 0, 0, S_UPD);
        push(0, 0, 0, S_NONE);
        return;
      end
      for (int t = 0; t < u; t++) push(1, 0, 0, S_UPD);
      push(1, 0, 0, S_NONE);
      m_iter++;
      if (stable != 0 || m_iter == MAXIT) begin
        m_conv = (stable != 0) ? 1 : 0;
        push(1, 1, 0, S_NONE);
        push(0, 0, 0, S_NONE);
        return;
      end
    end
  endtask

  // Per-cycle input driver, called just after the falling edge
  task automatic drive(input int gap, input int u, input int abort_upd, input int stray);
    start = 1'b0;
    abort = 1'b0;
    if (bus.pt_ready && gap_cnt >= gap) begin
      bus.pt_valid = 1'b1;
      bus.pt_data  = pts[pi % 8];
      pi++;
    end else if (bus.pt_ready) begin
      bus.pt_valid = 1'b0;
      bus.pt_data  = 24'hDEAD00 | CW'(gap_cnt);
      gap_cnt++;
    end else begin
      gap_cnt = 0;
      bus.pt_valid = (gap == 0);
      bus.pt_data  = (gap == 0) ? pts[pi % 8] : 24'hBEEF00;
    end
    if (bus.pe_update) begin
      bus.update_done = (u == 1) || (ucnt == u - 1);
      if (abort_upd > 0 && ucnt == abort_upd - 1) abort = 1'b1;
      ucnt++;
    end else begin
      bus.update_done = (u == 1);
      ucnt = 0;
    end
    if (stray != 0 && bus.pe_receive_point) begin
      start = 1'b1;
      num_points = '0;
    end
  endtask

  task automatic run(input int n, input int d, input int gap, input int u,
                     input int stable, input int abort_upd, input int stray,
                     input int exp_len);
    int budget;
    @(negedge clk);
    #1;
    pi = 0; gap_cnt = 0; ucnt = 0;
    c_init = 0; c_start = 0; c_recv = 0; c_sort = 0;
    c_next = 0; c_inc = 0; c_upd = 0; c_done = 0;
    num_points = NW'(n);
    tree_depth = DW'(d);
    bus.all_stable = (stable != 0);
    start = 1'b1;
    plan(n, d, gap, u, stable, abort_upd);
    chk("trace_len", exp_q.size(), exp_len);
    chk_en = 1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      @(negedge clk);
      #1;
      drive(gap, u, abort_upd, stray);
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL run_timeout actual=%0d required=0 entries left", exp_q.size());
      exp_q.delete();
    end
    chk_en = 0;
  endtask

  initial begin
    logic [41:0] snap;
    bit seen;
    rst = 1'b1;
    start = 1'b0; abort = 1'b0;
    num_points = '0; tree_depth = '0;
    bus.pt_valid = 1'b0; bus.pt_data = '0;
    bus.update_done = 1'b0; bus.all_stable = 1'b0;
    repeat (2) @(negedge clk);
    snap = {busy, done, bus.pt_ready, bus.pe_en, bus.pe_init, bus.pe_start_iter,
            bus.pe_receive_point, bus.pe_sorting, bus.pe_next_level, bus.pe_inc,
            bus.pe_update, converged, iter_count, bus.point_out, 4'h0};
    chk("reset_state", snap, 0);
    #1 rst = 1'b0;

    // Nominal: N=4 D=3
    run(4, 3, 0, 1, 1, 0, 0, 42);
    chk("nom_init", c_init, 1);
    chk("nom_start", c_start, 1);
    chk("nom_recv", c_recv, 4);
    chk("nom_sort", c_sort, 12);
    chk("nom_next", c_next, 12);
    chk("nom_inc", c_inc, 4);
    chk("nom_done", c_done, 1);
    chk("nom_conv", converged, 1);
    chk("nom_iter", iter_count, 1);
    chk("nom_point", bus.point_out, 24'h010203);

    // Backpressure: N=3 D=2, 5 idle cycles before each point
    run(3, 2, 5, 1, 1, 0, 0, 42);
    chk("bp_recv", c_recv, 3);
    chk("bp_sort", c_sort, 6);
    chk("bp_next", c_next, 6);
    chk("bp_inc", c_inc, 3);
    chk("bp_point", bus.point_out, 24'hFF00FF);

    // Iteration cap: never stable, N=2 D=1, 2-cycle update
    run(2, 1, 0, 2, 0, 0, 0, 45);
    chk("cap_start", c_start, 3);
    chk("cap_recv", c_recv, 6);
    chk("cap_done", c_done, 1);
    chk("cap_conv", converged, 0);
    chk("cap_iter", iter_count, 3);

    // Zero points
    run(0, 3, 0, 1, 1, 0, 0, 2);
    chk("zero_strobes", c_init + c_start + c_recv + c_sort + c_next + c_inc + c_upd, 0);
    chk("zero_done", c_done, 1);
    chk("zero_iter", iter_count, 0);
    chk("zero_conv", converged, 0);

    // Async reset in the middle of SORT_B
    @(negedge clk);
    #1;
    pi = 0; gap_cnt = 0; ucnt = 0;
    num_points = NW'(2);
    tree_depth = DW'(3);
    bus.all_stable = 1'b1;
    start = 1'b1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      #1;
      drive(0, 1, 0, 0);
      if (bus.pe_next_level) seen = 1;
    end
    chk("reach_sort_b", seen, 1);
    chk("pre_rst_point", bus.point_out, 24'h0A1B2C);
    #2 rst = 1'b1;
    #1;
    snap = {busy, done, bus.pt_ready, bus.pe_en, bus.pe_init, bus.pe_start_iter,
            bus.pe_receive_point, bus.pe_sorting, bus.pe_next_level, bus.pe_inc,
            bus.pe_update, converged, iter_count, bus.point_out, 4'h0};
    chk("async_rst_outputs", snap, 0);
    cur_pt = '0; m_iter = 0; m_conv = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Clean run after reset: N=1 D=1
    run(1, 1, 0, 1, 1, 0, 0, 11);
    chk("post_rst_recv", c_recv, 1);
    chk("post_rst_sort", c_sort, 1);
    chk("post_rst_next", c_next, 1);
    chk("post_rst_inc", c_inc, 1);

    // Abort during a stalled update, with a stray start mid-run
    run(2, 2, 0, 1000, 1, 10, 1, 27);
    chk("abort_upd", c_upd, 10);
    chk("abort_done", c_done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_iter", iter_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
